// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM state type, gate bit positions and expected gate-output vectors
package gate_test_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NOT  = 2;
  localparam int G_NAND = 3;
  localparam int G_NOR  = 4;
  localparam int G_XOR  = 5;
  localparam int G_XNOR = 6;
  function automatic logic [6:0] gate_vec(input logic x, input logic y);
    logic [6:0] v;
    v         = '0;
    v[G_AND]  = x & y;
    v[G_OR]   = x | y;
    v[G_NOT]  = ~x;
    v[G_NAND] = ~(x & y);
    v[G_NOR]  = ~(x | y);
    v[G_XOR]  = x ^ y;
    v[G_XNOR] = ~(x ^ y);
    return v;
  endfunction
  // Resolve to 7'h5C, 7'h2E, 7'h2A, 7'h43
  localparam logic [6:0] EXP_00 = gate_vec(1'b0, 1'b0);
  localparam logic [6:0] EXP_01 = gate_vec(1'b0, 1'b1);
  localparam logic [6:0] EXP_10 = gate_vec(1'b1, 1'b0);
  localparam logic [6:0] EXP_11 = gate_vec(1'b1, 1'b1);
endpackage

// File: rtl/gate_expected_lut.sv
// gate_expected_lut: maps an {a,b} vector to the expected seven gate outputs
module gate_expected_lut
  import gate_test_pkg::*;
(
  input  logic [1:0] i_vec,
  output logic [6:0] o_exp
);
  always_comb o_exp = i_vec == 2'b00 ? EXP_00 : i_vec == 2'b01 ? EXP_01 : i_vec == 2'b10 ? EXP_10 : EXP_11;
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: drives every {a,b} combination into the gate block and checks its seven outputs
module gate_bist_ctrl
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [6:0]       gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LW = LOOPS > 1 ? $clog2(LOOPS) : 1;
  state_t           r_state;
  logic [1:0]       r_vec;
  logic [1:0]       r_fail_vec;
  logic [SW-1:0]    r_settle;
  logic [LW-1:0]    r_loop;
  logic             r_a;
  logic             r_b;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err_cnt;
  logic [6:0]       r_fail_mask;
  logic [6:0]       w_exp;
  logic [6:0]       w_mis;
  logic             w_settled;
  logic             w_last;
  gate_expected_lut u_lut (.i_vec(r_vec), .o_exp(w_exp));
  assign w_mis     = gate_out ^ w_exp;
  assign w_settled = r_settle == SW'(SETTLE_CYCLES - 1);
  assign w_last    = r_vec == 2'd3 && r_loop == LW'(LOOPS - 1);
  assign a         = r_a;
  assign b         = r_b;
  assign busy      = r_state == DRIVE || r_state == CHECK;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_vec  = r_fail_vec;
  assign fail_mask = r_fail_mask;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_settle    <= '0;
      r_loop      <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state     <= DRIVE;
          r_vec       <= '0;
          r_loop      <= '0;
          r_settle    <= '0;
          r_err_cnt   <= '0;
          r_pass      <= 1'b0;
          r_fail_vec  <= '0;
          r_fail_mask <= '0;
        end
        DRIVE: begin
          {r_a, r_b} <= r_vec;
          r_settle   <= r_settle + 1'b1;
          if (w_settled) r_state <= CHECK;
        end
        CHECK: begin
          // err_cnt is still zero only until the first mismatch of the run
          if (|w_mis) begin
            if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
            if (r_err_cnt == '0) begin
              r_fail_vec  <= r_vec;
              r_fail_mask <= w_mis;
            end
          end
          if (w_last) r_state <= DONE;
          else begin
            r_state  <= DRIVE;
            r_settle <= '0;
            r_vec    <= r_vec + 1'b1;
            if (r_vec == 2'd3) r_loop <= r_loop + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_pass  <= r_err_cnt == '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: scoreboarded bench for gate_bist_ctrl with faulty and lagging gate models
module tb_gate_bist_ctrl;
  typedef struct {
    int         dc;
    logic       p;
    logic [7:0] er;
    logic [1:0] fv;
    logic [6:0] fm;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  int cyc = 0, checks = 0, errors = 0, mode0 = 0, mode1 = 0, mode2 = 0, j0 = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [1:0] abq[$];
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1, a2, b2, busy2, done2, pass2;
  logic [7:0] err0, err2;
  logic [1:0] err1, fv0, fv1, fv2;
  logic [6:0] fm0, fm1, fm2, go0, go1, go2, lag0, lag1, lag2;

  function automatic logic [6:0] gm(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
  endfunction
  // mode: 0 good, 1 xor stuck at 0, 2 all outputs inverted, 3 outputs lag one cycle
  function automatic logic [6:0] apply(input int m, input logic [6:0] g, input logic [6:0] lg);
    return m == 1 ? (g & 7'h5F) : m == 2 ? ~g : m == 3 ? lg : g;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    lag0 <= gm(a0, b0);
    lag1 <= gm(a1, b1);
    lag2 <= gm(a2, b2);
  end
  assign go0 = apply(mode0, gm(a0, b0), lag0);
  assign go1 = apply(mode1, gm(a1, b1), lag1);
  assign go2 = apply(mode2, gm(a2, b2), lag2);

  gate_bist_ctrl u0 (.clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .gate_out(go0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0), .fail_mask(fm0));
  gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(2), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .gate_out(go1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fv1), .fail_mask(fm1));
  gate_bist_ctrl #(.SETTLE_CYCLES(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .gate_out(go2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2),
    .fail_mask(fm2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic score(input int id, input logic p, input logic [7:0] er, input logic [1:0] fv,
                       input logic [6:0] fm);
    exp_t e;
    int n;
    n = id == 0 ? q0.size() : id == 1 ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d unexpected done: got pulse expected none (cycle %0d)", id, cyc);
    end else begin
      if (id == 0) e = q0.pop_front();
      else if (id == 1) e = q1.pop_front();
      else e = q2.pop_front();
      chk($sformatf("u%0d done cycle", id), cyc, e.dc);
      chk($sformatf("u%0d pass", id), p, e.p);
      chk($sformatf("u%0d err_cnt", id), er, e.er);
      chk($sformatf("u%0d fail_vec", id), fv, e.fv);
      chk($sformatf("u%0d fail_mask", id), fm, e.fm);
    end
  endtask

  always @(negedge clk) if (done0 !== 1'b0) score(0, pass0, err0, fv0, fm0);
  always @(negedge clk) if (done1 !== 1'b0) score(1, pass1, {6'b0, err1}, fv1, fm1);
  always @(negedge clk) if (done2 !== 1'b0) score(2, pass2, err2, fv2, fm2);

  // u0 uses two settle cycles, so every third busy cycle (index 2, 5, 8, 11) is a CHECK
  always @(negedge clk) begin
    if (busy0 === 1'b1) begin
      if (j0 % 3 == 2 && abq.size() > 0) chk("u0 a/b at check", {a0, b0}, abq.pop_front());
      j0++;
    end else j0 = 0;
  end

  task automatic run(input int id, input logic p, input logic [7:0] er, input logic [1:0] fv,
                     input logic [6:0] fm);
    exp_t e;
    e.dc = cyc + 1 + (id == 0 ? 13 : id == 1 ? 25 : 9);
    e.p  = p;
    e.er = er;
    e.fv = fv;
    e.fm = fm;
    if (id == 0) begin
      q0.push_back(e);
      for (int i = 0; i < 4; i++) abq.push_back(2'(i));
      start0 = 1'b1;
    end else if (id == 1) begin
      q1.push_back(e);
      start1 = 1'b1;
    end else begin
      q2.push_back(e);
      start2 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: got %0d pending runs expected 0", q0.size() + q1.size() + q2.size());
      q0.delete();
      q1.delete();
      q2.delete();
      abq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int n;
    repeat (2) @(negedge clk);
    chk("reset a", a0, 0);
    chk("reset b", b0, 0);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset pass", pass0, 0);
    chk("reset err_cnt", err0, 0);
    chk("reset fail_vec", fv0, 0);
    chk("reset fail_mask", fm0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mode0 = 0;
    run(0, 1'b1, 8'd0, 2'b00, 7'h00);
    drain();
    mode0 = 1;
    run(0, 1'b0, 8'd2, 2'b01, 7'h20);
    drain();
    mode1 = 2;
    run(1, 1'b0, 8'd3, 2'b00, 7'h7F);
    drain();
    // start held high: one run, then a second one sampled right after DONE returns to IDLE
    mode0 = 0;
    e = '{dc: cyc + 14, p: 1'b1, er: 8'd0, fv: 2'b00, fm: 7'h00};
    q0.push_back(e);
    e.dc = e.dc + 14;
    q0.push_back(e);
    for (int i = 0; i < 8; i++) abq.push_back(2'(i % 4));
    start0 = 1'b1;
    n = 0;
    while (done0 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("held start first done seen", done0, 1);
    chk("held start busy in done cycle", busy0, 0);
    @(negedge clk);
    chk("held start busy restarts", busy0, 1);
    start0 = 1'b0;
    drain();
    // reset during vec 2 with a failing gate model
    mode0 = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!(busy0 === 1'b1 && {a0, b0} == 2'b10) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre-reset vec 2 reached", {busy0, a0, b0}, 3'b110);
    chk("pre-reset err_cnt", err0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    abq.delete();
    @(negedge clk);
    chk("mid reset outputs", {a0, b0, busy0, done0, pass0, err0, fv0, fm0}, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    mode0 = 0;
    run(0, 1'b1, 8'd0, 2'b00, 7'h00);
    drain();
    // lagging gate outputs: one settle cycle catches it, two settle cycles hide it
    mode2 = 3;
    run(2, 1'b0, 8'd3, 2'b01, 7'h72);
    drain();
    mode0 = 3;
    run(0, 1'b1, 8'd0, 2'b00, 7'h00);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end
endmodule
